// File: rtl/cond_code_unit.sv
// Condition-code unit: holds the ALU status flags {N,Z,C,V}, returns C as Cin,
// and resolves instruction condition fields through a request/ack FSM.
module cond_code_unit #(
  parameter logic [3:0] FLAGS_RST   = 4'b0000,
  parameter int         ACK_TIMEOUT = 16,
  parameter int         CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_c,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       s_bit,
  input  logic [3:0] cond,
  input  logic       eval_req,
  input  logic       branch_ack,
  output logic       cin,
  output logic [3:0] flags,
  output logic       cond_true,
  output logic       eval_done,
  output logic       branch_valid,
  output logic       timeout_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EVAL, WAIT_ACK} state_t;

  localparam bit             TIMEOUT_EN = (ACK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [3:0]       cond_q, cond_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ct_nxt, done_nxt, bv_nxt, te_nxt;
  logic             dec;

  function automatic logic decode(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:    decode = z;
      4'd1:    decode = !z;
      4'd2:    decode = cy;
      4'd3:    decode = !cy;
      4'd4:    decode = n;
      4'd5:    decode = !n;
      4'd6:    decode = v;
      4'd7:    decode = !v;
      4'd8:    decode = cy & !z;
      4'd9:    decode = !cy | z;
      4'd10:   decode = (n == v);
      4'd11:   decode = (n != v);
      4'd12:   decode = !z & (n == v);
      4'd13:   decode = z | (n != v);
      4'd14:   decode = 1'b1;
      default: decode = 1'b0;
    endcase
  endfunction

  // Status register is written by s_bit regardless of FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      flags <= FLAGS_RST;
    else if (s_bit) flags <= {alu_n, alu_z, alu_c, alu_v};
  end

  assign cin  = flags[1];
  assign busy = (state != IDLE);
  assign dec  = decode(cond_q, flags);

  always_comb begin
    state_nxt = state;
    cond_nxt  = cond_q;
    cnt_nxt   = cnt;
    ct_nxt    = cond_true;
    done_nxt  = 1'b0;
    bv_nxt    = branch_valid;
    te_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (eval_req) begin
          cond_nxt  = cond;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        ct_nxt   = dec;
        done_nxt = 1'b1;
        if (dec) begin
          bv_nxt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WAIT_ACK;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_ACK: begin
        cnt_nxt = cnt + 1'b1;
        // Ack takes priority over a coincident timeout.
        if (branch_ack) begin
          bv_nxt    = 1'b0;
          state_nxt = IDLE;
        end else if (TIMEOUT_EN && cnt == CNT_LAST) begin
          bv_nxt    = 1'b0;
          te_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cond_q       <= '0;
      cnt          <= '0;
      cond_true    <= 1'b0;
      eval_done    <= 1'b0;
      branch_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cond_q       <= cond_nxt;
      cnt          <= cnt_nxt;
      cond_true    <= ct_nxt;
      eval_done    <= done_nxt;
      branch_valid <= bv_nxt;
      timeout_err  <= te_nxt;
    end
  end

endmodule
